// File: rtl/jtkcpu_mul_pkg.sv
// jtkcpu_mul_pkg: multiplier FSM encodings and per-radix step counts (JTKCPU_MUL_RADIX4_EN selects radix-4)
package jtkcpu_mul_pkg;
  localparam logic [1:0] MUL_IDLE = 2'd0;
  localparam logic [1:0] MUL_RUN  = 2'd1;
  localparam logic [1:0] MUL_DONE = 2'd2;
`ifdef JTKCPU_MUL_RADIX4_EN
  localparam logic [4:0] MUL_STEPS8  = 5'd4;
  localparam logic [4:0] MUL_STEPS16 = 5'd8;
`else
  localparam logic [4:0] MUL_STEPS8  = 5'd8;
  localparam logic [4:0] MUL_STEPS16 = 5'd16;
`endif
endpackage

// File: rtl/jtkcpu_mul.sv
// jtkcpu_mul: multi-cycle shift-add multiplier for MUL (8x8) and LMUL (16x16)
// JTKCPU_MUL_RADIX4_EN defined: two multiplier bits retired per cen, otherwise one
module jtkcpu_mul
  import jtkcpu_mul_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         start,
  input  logic         len,
  input  logic [W-1:0] op0,
  input  logic [W-1:0] op1,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic [W-1:0] rslt_hi,
  output logic         c,
  output logic         z
);
  logic [1:0]     st;
  logic [4:0]     cnt;
  logic           lmul;
  logic [W-1:0]   mcand, acc, mpl, acc_n, mpl_n, mc_ld, mp_ld;
  logic [2*W-1:0] prod;
`ifdef JTKCPU_MUL_RADIX4_EN
  logic [W+1:0]   m3, sum;
`else
  logic [W:0]     sum;
`endif
  assign busy = st == MUL_RUN;
  assign done = st == MUL_DONE;
  always_comb begin
    mc_ld = len ? op0 : {{(W-8){1'b0}}, op0[15:8]};
    mp_ld = len ? op1 : {{(W-8){1'b0}}, op0[7:0]};
`ifdef JTKCPU_MUL_RADIX4_EN
    sum   = {2'b0, acc} + (mpl[1] ? (mpl[0] ? m3 : {1'b0, mcand, 1'b0}) : (mpl[0] ? {2'b0, mcand} : '0));
    acc_n = sum[W+1:2];
    mpl_n = {sum[1:0], mpl[W-1:2]};
`else
    sum   = {1'b0, acc} + (mpl[0] ? {1'b0, mcand} : '0);
    acc_n = sum[W:1];
    mpl_n = {sum[0], mpl[W-1:1]};
`endif
    // MUL runs half the steps, so its 16-bit product sits 8 bits up in {acc,mpl}
    prod  = lmul ? {acc_n, mpl_n} : {{W{1'b0}}, acc_n[7:0], mpl_n[W-1:8]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= MUL_IDLE;
      cnt     <= '0;
      lmul    <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      mpl     <= '0;
      rslt    <= '0;
      rslt_hi <= '0;
      c       <= 1'b0;
      z       <= 1'b0;
`ifdef JTKCPU_MUL_RADIX4_EN
      m3      <= '0;
`endif
    end else if (st == MUL_DONE) begin
      st <= MUL_IDLE;
    end else if (cen) begin
      if (st == MUL_IDLE && start) begin
        st    <= MUL_RUN;
        cnt   <= len ? MUL_STEPS16 : MUL_STEPS8;
        lmul  <= len;
        mcand <= mc_ld;
        mpl   <= mp_ld;
        acc   <= '0;
`ifdef JTKCPU_MUL_RADIX4_EN
        m3    <= {2'b0, mc_ld} + {1'b0, mc_ld, 1'b0};
`endif
      end else if (st == MUL_RUN) begin
        acc <= acc_n;
        mpl <= mpl_n;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          st      <= MUL_DONE;
          rslt    <= prod[W-1:0];
          rslt_hi <= prod[2*W-1:W];
          c       <= lmul ? prod[2*W-1] : prod[15];
          z       <= prod == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtkcpu_mul.sv
// tb_jtkcpu_mul: directed bench with an arithmetic reference model checked every cycle
module tb_jtkcpu_mul;
`ifdef JTKCPU_MUL_RADIX4_EN
  localparam int S8 = 4, S16 = 8;
`else
  localparam int S8 = 8, S16 = 16;
`endif
  logic        clk = 0, rst_n = 0, cen = 0, start = 0, len = 0;
  logic [15:0] op0 = 0, op1 = 0;
  logic        busy, done, c, z;
  logic [15:0] rslt, rslt_hi;
  int          n_tests = 0, n_fail = 0;
  logic        chk_en = 0;
  jtkcpu_mul #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .len(len), .op0(op0), .op1(op1),
    .busy(busy), .done(done), .rslt(rslt), .rslt_hi(rslt_hi), .c(c), .z(z)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  // reference: product from plain multiplication, timing from cen-cycle counts
  logic        m_busy = 0, m_done = 0, m_len = 0, m_c = 0, m_z = 0;
  logic [31:0] m_p = 0, m_prod = 0;
  int          m_left = 0;
  always @(posedge clk) begin
    logic was_done;
    was_done = m_done;
    m_done = 0;
    if (!rst_n) begin
      m_busy = 0; m_left = 0; m_prod = 0; m_c = 0; m_z = 0;
    end else if (cen) begin
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_prod = m_p;
          m_c = m_len ? m_p[31] : m_p[15];
          m_z = m_p == 0;
        end
      end else if (start && !was_done) begin
        m_busy = 1; m_len = len;
        m_p = len ? {16'b0, op0} * {16'b0, op1} : {24'b0, op0[15:8]} * {24'b0, op0[7:0]};
        m_left = len ? S16 : S8;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("prod", {rslt_hi, rslt}, m_prod);
    chk("c", {31'b0, c}, {31'b0, m_c});
    chk("z", {31'b0, z}, {31'b0, m_z});
  end
  int lat, bc, dn;
  task automatic do_op(input logic l, input logic [15:0] a, input logic [15:0] b,
                       input bit toggle, input bit hold);
    bit seen;
    seen = 0; lat = 0; bc = 0; dn = 0;
    @(negedge clk);
    len = l; op0 = a; op1 = b; start = 1; cen = 1;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (cen) lat++;
      if (busy && cen) bc++;
      @(negedge clk);
      if (!hold) start = 0;
      if (hold && k == 3) op0 = 16'hFFFF;
      if (done) begin seen = 1; dn++; start = 0; cen = 1; end
      else cen = toggle ? ~cen : 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rslt", {rslt_hi, rslt}, 0);
    chk("rst_cz", {30'b0, c, z}, 0);
    rst_n = 1;
    do_op(0, 16'h0C0D, 0, 0, 0);
    chk("t1_rslt", {rslt_hi, rslt}, 32'h0000_009C);
    chk("t1_cz", {30'b0, c, z}, 0);
    chk("t1_lat", lat, S8 + 1);
    chk("t1_dones", dn, 1);
    do_op(0, 16'hFFFF, 0, 0, 0);
    chk("t2a_rslt", {rslt_hi, rslt}, 32'h0000_FE01);
    chk("t2a_cz", {30'b0, c, z}, 2);
    do_op(0, 16'h00FF, 16'hFFFF, 0, 0);
    chk("t2b_rslt", {rslt_hi, rslt}, 0);
    chk("t2b_cz", {30'b0, c, z}, 1);
    do_op(1, 16'hFFFF, 16'hFFFF, 0, 0);
    chk("t3_rslt", {rslt_hi, rslt}, 32'hFFFE_0001);
    chk("t3_c", {31'b0, c}, 1);
    chk("t3_lat", lat, S16 + 1);
    do_op(1, 16'h1234, 16'h0000, 1, 0);
    chk("t4_z", {31'b0, z}, 1);
    chk("t4_busy_cen", bc, S16);
    do_op(1, 16'h0101, 16'h0003, 1, 0);
    chk("t4b_rslt", {rslt_hi, rslt}, 32'h0000_0303);
    do_op(0, 16'h0C0D, 0, 0, 1);
    chk("t5_dones", dn, 1);
    chk("t5_rslt", {rslt_hi, rslt}, 32'h0000_009C);
    @(negedge clk);
    len = 1; op0 = 16'h1234; op1 = 16'h5678; start = 1; cen = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t6_busy", {31'b0, busy}, 0);
    chk("t6_done", {31'b0, done}, 0);
    chk("t6_rslt", {rslt_hi, rslt}, 0);
    rst_n = 1;
    dn = 0;
    repeat (20) begin @(negedge clk); if (done) dn++; end
    chk("t6_no_done", dn, 0);
    do_op(0, 16'h0302, 0, 0, 0);
    chk("t6_rslt_new", {rslt_hi, rslt}, 32'h0000_0006);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
